// File: rtl/uart_alu_pkg.sv
// rtl/uart_alu_pkg.sv - shared types, constants and helpers for the UART/ALU frame bridge
package uart_alu_pkg;

    // State encoding of the frame FSM
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GET_A  = 3'd1;
    localparam logic [2:0] ST_GET_B  = 3'd2;
    localparam logic [2:0] ST_GET_OP = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_PUSH   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        GET_A  = ST_GET_A,
        GET_B  = ST_GET_B,
        GET_OP = ST_GET_OP,
        EXEC   = ST_EXEC,
        PUSH   = ST_PUSH
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Ceiling log2; 0 for values of 1 or less
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Bits needed to hold 0..max_value, never less than one
    function automatic int cnt_width(input int max_value);
        int w;
        w = clog2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // True when the word (data plus parity bit, zero-extended) has even parity
    function automatic logic parity_ok(input logic [63:0] word);
        return ~(^word);
    endfunction

endpackage

// File: rtl/uart_alu_frame_interface_fifo.sv
// rtl/uart_alu_frame_interface_fifo.sv - synchronous FIFO with show-ahead head output
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (pointers only)
//   wr_en, wr_data   push request and data; a push on full is taken only
//                    when a pop happens in the same cycle
//   rd_en            pop request; ignored while empty
//   rd_data          current head word (valid while !empty)
//   empty, full      occupancy flags
module uart_alu_frame_interface_fifo
    import uart_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_alu_frame_interface.sv
// rtl/uart_alu_frame_interface.sv - framed bridge from UART rx/tx to the ALU
//
// Frame on the rx side: SOF_BYTE, operand A, operand B, opcode. Operands and
// opcode are presented to the ALU with a one-cycle o_alu_valid pulse, the
// result is sampled ALU_LATENCY cycles later and queued for transmission.
//
// Ports:
//   i_clk, i_rst       clock, asynchronous active-low reset
//   i_rx_data/done     received word (parity bit in MSB when PARITY_CHECK=1) and strobe
//   i_tx_done          transmitter finished the current word (pops TX FIFO)
//   i_alu_data         ALU result
//   o_alu_data_a/b/op  operands and opcode, held between frames
//   o_alu_valid        pulse when a new operand set is loaded
//   o_tx_data          head of TX FIFO (0 while empty)
//   o_tx_start         TX FIFO non-empty
//   o_frame_err        pulse on parity error or inter-byte timeout
//   o_err_count        saturating error count
module uart_alu_frame_interface
    import uart_alu_pkg::*;
#(
    parameter int                N_DATA         = 8,
    parameter int                PARITY_CHECK   = 0,
    parameter int                NB_OPERATION   = 6,
    parameter int                N_WORD_BUFFER  = 4,
    parameter logic [N_DATA-1:0] SOF_BYTE       = N_DATA'(SOF_DEFAULT),
    parameter int                ALU_LATENCY    = 0,
    parameter int                TIMEOUT_CYCLES = 1000000,
    parameter int                NB_ERR_COUNT   = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_DATA+PARITY_CHECK-1:0] i_rx_data,
    input  logic                       i_rx_done,
    input  logic                       i_tx_done,
    input  logic [N_DATA-1:0]          i_alu_data,
    output logic [N_DATA-1:0]          o_alu_data_a,
    output logic [N_DATA-1:0]          o_alu_data_b,
    output logic [NB_OPERATION-1:0]    o_alu_data_op,
    output logic                       o_alu_valid,
    output logic [N_DATA-1:0]          o_tx_data,
    output logic                       o_tx_start,
    output logic                       o_frame_err,
    output logic [NB_ERR_COUNT-1:0]    o_err_count
);

    localparam int RX_W  = N_DATA + PARITY_CHECK;
    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);
    localparam int LAT_W = cnt_width(ALU_LATENCY);

    state_t              state;
    state_t              state_nxt;

    logic [RX_W-1:0]     rx_word;
    logic [N_DATA-1:0]   rx_bits;
    logic                rx_empty;
    logic                rx_full;
    logic                rx_push;
    logic                rx_pop;

    logic [N_DATA-1:0]   tx_head;
    logic                tx_empty;
    logic                tx_full;
    logic                tx_push;

    logic [N_DATA-1:0]   a_shadow;
    logic [N_DATA-1:0]   b_shadow;
    logic [N_DATA-1:0]   result;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [LAT_W-1:0]    lat_cnt;

    logic                in_get;
    logic                par_good;
    logic                par_err;
    logic                tmo_hit;
    logic                err;
    logic                lat_done;
    logic                load_a;
    logic                load_b;
    logic                load_op;

    assign rx_push = i_rx_done && !rx_full;

    uart_alu_frame_interface_fifo #(
        .WIDTH (RX_W),
        .DEPTH (N_WORD_BUFFER)
    ) u_rx_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .wr_en   (rx_push),
        .wr_data (i_rx_data),
        .rd_en   (rx_pop),
        .rd_data (rx_word),
        .empty   (rx_empty),
        .full    (rx_full)
    );

    uart_alu_frame_interface_fifo #(
        .WIDTH (N_DATA),
        .DEPTH (N_WORD_BUFFER)
    ) u_tx_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .wr_en   (tx_push),
        .wr_data (result),
        .rd_en   (i_tx_done),
        .rd_data (tx_head),
        .empty   (tx_empty),
        .full    (tx_full)
    );

    assign o_tx_start = !tx_empty;
    assign o_tx_data  = tx_empty ? '0 : tx_head;

    assign rx_bits  = rx_word[N_DATA-1:0];
    assign in_get   = (state == GET_A) || (state == GET_B) || (state == GET_OP);
    assign rx_pop   = !rx_empty && ((state == IDLE) || in_get);
    assign par_good = (PARITY_CHECK == 0) || parity_ok(64'(rx_word));
    // In IDLE only a corrupted start marker counts as an error; other noise is dropped quietly
    assign par_err  = rx_pop && !par_good && (in_get || (rx_bits == SOF_BYTE));
    // Timeout fires on the idle cycle that would bring the counter to TIMEOUT_CYCLES
    assign tmo_hit  = in_get && !rx_pop && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign err      = par_err || tmo_hit;
    assign lat_done = (lat_cnt == LAT_W'(ALU_LATENCY));
    // A push on a full TX FIFO is fine when the transmitter pops in the same cycle
    assign tx_push  = (state == PUSH) && (!tx_full || i_tx_done);

    always_comb begin
        state_nxt = state;
        load_a    = 1'b0;
        load_b    = 1'b0;
        load_op   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_pop && par_good && (rx_bits == SOF_BYTE)) begin
                    state_nxt = GET_A;
                end
            end
            GET_A: begin
                if (err) begin
                    state_nxt = IDLE;
                end else if (rx_pop) begin
                    load_a    = 1'b1;
                    state_nxt = GET_B;
                end
            end
            GET_B: begin
                if (err) begin
                    state_nxt = IDLE;
                end else if (rx_pop) begin
                    load_b    = 1'b1;
                    state_nxt = GET_OP;
                end
            end
            GET_OP: begin
                if (err) begin
                    state_nxt = IDLE;
                end else if (rx_pop) begin
                    load_op   = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (lat_done) begin
                    state_nxt = PUSH;
                end
            end
            PUSH: begin
                if (tx_push) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            a_shadow      <= '0;
            b_shadow      <= '0;
            o_alu_data_a  <= '0;
            o_alu_data_b  <= '0;
            o_alu_data_op <= '0;
            o_alu_valid   <= 1'b0;
            o_frame_err   <= 1'b0;
            o_err_count   <= '0;
            tmo_cnt       <= '0;
            lat_cnt       <= '0;
            result        <= '0;
        end else begin
            o_alu_valid <= load_op;
            o_frame_err <= err;

            if (load_a) begin
                a_shadow <= rx_bits;
            end
            if (load_b) begin
                b_shadow <= rx_bits;
            end
            if (load_op) begin
                o_alu_data_a  <= a_shadow;
                o_alu_data_b  <= b_shadow;
                o_alu_data_op <= rx_word[NB_OPERATION-1:0];
            end

            if (err && (o_err_count != '1)) begin
                o_err_count <= o_err_count + 1'b1;
            end

            if (!in_get || rx_pop || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            // With zero latency the result is sampled in the o_alu_valid cycle itself
            if ((state == EXEC) && !lat_done) begin
                lat_cnt <= lat_cnt + 1'b1;
            end else begin
                lat_cnt <= '0;
            end

            if ((state == EXEC) && lat_done) begin
                result <= i_alu_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_frame_interface.sv
// tb/tb_uart_alu_frame_interface.sv - directed self-checking bench for uart_alu_frame_interface
module tb_uart_alu_frame_interface;

    logic       clk;
    logic       i_rst;
    logic [8:0] i_rx_data;
    logic       i_rx_done;
    logic       i_tx_done;
    logic [7:0] i_alu_data;
    logic [7:0] o_alu_data_a;
    logic [7:0] o_alu_data_b;
    logic [5:0] o_alu_data_op;
    logic       o_alu_valid;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_frame_err;
    logic [7:0] o_err_count;

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc = 0;
    int         valid_cnt = 0;
    int         valid_cyc = 0;
    int         err_pulses = 0;
    int         err_cyc = 0;
    int         last_rx_cyc = 0;
    logic [7:0] last_a = 0;
    logic [7:0] last_b = 0;
    logic [5:0] last_op = 0;
    logic       tx_hold = 0;
    logic [7:0] tx_q[$];
    int         tx_cyc_q[$];

    uart_alu_frame_interface #(
        .N_DATA         (8),
        .PARITY_CHECK   (1),
        .NB_OPERATION   (6),
        .N_WORD_BUFFER  (4),
        .SOF_BYTE       (8'hA5),
        .ALU_LATENCY    (2),
        .TIMEOUT_CYCLES (50),
        .NB_ERR_COUNT   (8)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_rx_data     (i_rx_data),
        .i_rx_done     (i_rx_done),
        .i_tx_done     (i_tx_done),
        .i_alu_data    (i_alu_data),
        .o_alu_data_a  (o_alu_data_a),
        .o_alu_data_b  (o_alu_data_b),
        .o_alu_data_op (o_alu_data_op),
        .o_alu_valid   (o_alu_valid),
        .o_tx_data     (o_tx_data),
        .o_tx_start    (o_tx_start),
        .o_frame_err   (o_frame_err),
        .o_err_count   (o_err_count)
    );

    // ALU model: A + B
    assign i_alu_data = o_alu_data_a + o_alu_data_b;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Negedge observer and transmitter model
    initial begin
        i_tx_done = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!i_rst) begin
                i_tx_done = 0;
            end else begin
                if (i_rx_done) last_rx_cyc = cyc;
                if (o_alu_valid) begin
                    valid_cnt++;
                    valid_cyc = cyc;
                    last_a  = o_alu_data_a;
                    last_b  = o_alu_data_b;
                    last_op = o_alu_data_op;
                end
                if (o_frame_err) begin
                    err_pulses++;
                    err_cyc = cyc;
                end
                if (o_tx_start && !tx_hold && !i_tx_done) begin
                    tx_q.push_back(o_tx_data);
                    tx_cyc_q.push_back(cyc);
                    i_tx_done = 1;
                end else begin
                    i_tx_done = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t want finish", $time);
        $fatal(1);
    end

    task automatic send_word(input logic [7:0] b, input logic bad);
        @(posedge clk); #1;
        i_rx_data = {(^b) ^ bad, b};
        i_rx_done = 1;
    endtask

    task automatic rx_idle();
        @(posedge clk); #1;
        i_rx_done = 0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_word(8'hA5, 0);
        send_word(a, 0);
        send_word(b, 0);
        send_word(op, 0);
        rx_idle();
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int i = 0; i < budget && tx_q.size() < n; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic clear_q();
        tx_q.delete();
        tx_cyc_q.delete();
    endtask

    task automatic test_reset();
        i_rst = 0; i_rx_done = 0; i_rx_data = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (o_alu_data_a !== 8'h00)  begin n_fail++; $display("FAIL rst_a: got %h want 00", o_alu_data_a); end
        n_checks++; if (o_alu_data_b !== 8'h00)  begin n_fail++; $display("FAIL rst_b: got %h want 00", o_alu_data_b); end
        n_checks++; if (o_alu_data_op !== 6'h00) begin n_fail++; $display("FAIL rst_op: got %h want 00", o_alu_data_op); end
        n_checks++; if (o_alu_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_alu_valid); end
        n_checks++; if (o_frame_err !== 1'b0)    begin n_fail++; $display("FAIL rst_err: got %b want 0", o_frame_err); end
        n_checks++; if (o_err_count !== 8'h00)   begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", o_err_count); end
        n_checks++; if (o_tx_start !== 1'b0)     begin n_fail++; $display("FAIL rst_tx_start: got %b want 0", o_tx_start); end
        n_checks++; if (o_tx_data !== 8'h00)     begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", o_tx_data); end
        @(posedge clk); #1;
        i_rst = 1;
    endtask

    task automatic test_basic();
        int v0;
        v0 = valid_cnt;
        clear_q();
        send_frame(8'h03, 8'h05, 8'h20);
        wait_tx(1, 50);
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL basic_valid_cnt: got %0d want 1", valid_cnt - v0); end
        n_checks++; if (last_a !== 8'h03)  begin n_fail++; $display("FAIL basic_a: got %h want 03", last_a); end
        n_checks++; if (last_b !== 8'h05)  begin n_fail++; $display("FAIL basic_b: got %h want 05", last_b); end
        n_checks++; if (last_op !== 6'h20) begin n_fail++; $display("FAIL basic_op: got %h want 20", last_op); end
        n_checks++; if (valid_cyc - last_rx_cyc !== 2) begin n_fail++; $display("FAIL basic_valid_lat: got %0d want 2", valid_cyc - last_rx_cyc); end
        n_checks++; if (tx_q.size() !== 1) begin n_fail++; $display("FAIL basic_tx_size: got %0d want 1", tx_q.size()); end
        if (tx_q.size() > 0) begin
            n_checks++; if (tx_q[0] !== 8'h08) begin n_fail++; $display("FAIL basic_tx_data: got %h want 08", tx_q[0]); end
            n_checks++; if (tx_cyc_q[0] - valid_cyc !== 4) begin n_fail++; $display("FAIL basic_tx_lat: got %0d want 4", tx_cyc_q[0] - valid_cyc); end
        end
    endtask

    task automatic test_garbage();
        int e0;
        e0 = err_pulses;
        clear_q();
        send_word(8'h11, 0);
        send_word(8'h22, 0);
        send_frame(8'h0A, 8'h01, 8'h20);
        wait_tx(1, 50);
        n_checks++; if (err_pulses !== e0) begin n_fail++; $display("FAIL garbage_err: got %0d want %0d", err_pulses, e0); end
        n_checks++; if (o_err_count !== 8'd0) begin n_fail++; $display("FAIL garbage_cnt: got %0d want 0", o_err_count); end
        n_checks++; if (last_a !== 8'h0A || last_b !== 8'h01) begin n_fail++; $display("FAIL garbage_ops: got %h/%h want 0a/01", last_a, last_b); end
        n_checks++; if (tx_q.size() !== 1 || tx_q[0] !== 8'h0B) begin n_fail++; $display("FAIL garbage_tx: got size %0d first %h want 1 0b", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
    endtask

    task automatic test_parity();
        int e0, v0;
        e0 = err_pulses; v0 = valid_cnt;
        clear_q();
        send_word(8'hA5, 0);
        send_word(8'h01, 0);
        send_word(8'h02, 1);
        rx_idle();
        repeat (10) @(negedge clk);
        n_checks++; if (err_pulses - e0 !== 1) begin n_fail++; $display("FAIL parity_pulse: got %0d want 1", err_pulses - e0); end
        n_checks++; if (o_err_count !== 8'd1) begin n_fail++; $display("FAIL parity_cnt: got %0d want 1", o_err_count); end
        n_checks++; if (valid_cnt !== v0) begin n_fail++; $display("FAIL parity_no_valid: got %0d want %0d", valid_cnt, v0); end
        n_checks++; if (tx_q.size() !== 0) begin n_fail++; $display("FAIL parity_no_tx: got %0d want 0", tx_q.size()); end
        n_checks++; if (o_alu_data_a !== 8'h0A || o_alu_data_b !== 8'h01) begin n_fail++; $display("FAIL parity_hold: got %h/%h want 0a/01", o_alu_data_a, o_alu_data_b); end
        send_frame(8'h04, 8'h04, 8'h21);
        wait_tx(1, 50);
        n_checks++; if (last_op !== 6'h21) begin n_fail++; $display("FAIL parity_next_op: got %h want 21", last_op); end
        n_checks++; if (tx_q.size() !== 1 || tx_q[0] !== 8'h08) begin n_fail++; $display("FAIL parity_next_tx: got size %0d first %h want 1 08", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
    endtask

    task automatic test_timeout();
        int e0, v0;
        e0 = err_pulses; v0 = valid_cnt;
        clear_q();
        send_word(8'hA5, 0);
        send_word(8'h01, 0);
        rx_idle();
        repeat (60) @(negedge clk);
        n_checks++; if (err_pulses - e0 !== 1) begin n_fail++; $display("FAIL tmo_pulse: got %0d want 1", err_pulses - e0); end
        n_checks++; if (err_cyc - last_rx_cyc !== 52) begin n_fail++; $display("FAIL tmo_timing: got %0d want 52", err_cyc - last_rx_cyc); end
        n_checks++; if (o_err_count !== 8'd2) begin n_fail++; $display("FAIL tmo_cnt: got %0d want 2", o_err_count); end
        n_checks++; if (valid_cnt !== v0) begin n_fail++; $display("FAIL tmo_no_valid: got %0d want %0d", valid_cnt, v0); end
        send_frame(8'h02, 8'h03, 8'h04);
        wait_tx(1, 50);
        n_checks++; if (tx_q.size() !== 1 || tx_q[0] !== 8'h05) begin n_fail++; $display("FAIL tmo_next_tx: got size %0d first %h want 1 05", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
    endtask

    task automatic test_back_to_back();
        int v0;
        logic [7:0] exp_q[$];
        logic [7:0] a, b;
        v0 = valid_cnt;
        clear_q();
        tx_hold = 1;
        for (int i = 0; i < 6; i++) begin
            a = 8'h11 + 8'(i);
            b = 8'h20 + 8'(2 * i);
            exp_q.push_back(a + b);
            send_frame(a, b, 8'h01);
            repeat (10) @(negedge clk);
        end
        n_checks++; if (valid_cnt - v0 !== 5) begin n_fail++; $display("FAIL bp_stall_valid: got %0d want 5", valid_cnt - v0); end
        n_checks++; if (o_tx_start !== 1'b1 || tx_q.size() !== 0) begin n_fail++; $display("FAIL bp_held: got start %b size %0d want 1 0", o_tx_start, tx_q.size()); end
        tx_hold = 0;
        wait_tx(6, 300);
        n_checks++; if (tx_q.size() !== 6) begin n_fail++; $display("FAIL bp_drain_size: got %0d want 6", tx_q.size()); end
        for (int i = 0; i < 6 && i < tx_q.size(); i++) begin
            n_checks++; if (tx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, tx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_saturation();
        int e0;
        e0 = err_pulses;
        for (int i = 0; i < 300; i++) send_word(8'hA5, 1);
        rx_idle();
        repeat (10) @(negedge clk);
        n_checks++; if (err_pulses - e0 !== 300) begin n_fail++; $display("FAIL sat_pulses: got %0d want 300", err_pulses - e0); end
        n_checks++; if (o_err_count !== 8'd255) begin n_fail++; $display("FAIL sat_cnt: got %0d want 255", o_err_count); end
    endtask

    task automatic test_reset_midframe();
        clear_q();
        tx_hold = 1;
        send_frame(8'h05, 8'h06, 8'h01);
        repeat (15) @(negedge clk);
        n_checks++; if (o_tx_start !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b want 1", o_tx_start); end
        send_word(8'hA5, 0);
        send_word(8'h07, 0);
        rx_idle();
        i_rst = 0;
        #1;
        n_checks++; if (o_alu_data_a !== 8'h00 || o_alu_data_b !== 8'h00 || o_alu_data_op !== 6'h00) begin n_fail++; $display("FAIL mid_ops: got %h/%h/%h want 00/00/00", o_alu_data_a, o_alu_data_b, o_alu_data_op); end
        n_checks++; if (o_alu_valid !== 1'b0 || o_frame_err !== 1'b0) begin n_fail++; $display("FAIL mid_pulses: got %b/%b want 0/0", o_alu_valid, o_frame_err); end
        n_checks++; if (o_err_count !== 8'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d want 0", o_err_count); end
        n_checks++; if (o_tx_start !== 1'b0 || o_tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_tx: got %b/%h want 0/00", o_tx_start, o_tx_data); end
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1;
        tx_hold = 0;
        send_frame(8'h09, 8'h01, 8'h02);
        wait_tx(1, 50);
        repeat (5) @(negedge clk);
        n_checks++; if (tx_q.size() !== 1 || tx_q[0] !== 8'h0A) begin n_fail++; $display("FAIL mid_after: got size %0d first %h want 1 0a", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_garbage();
        test_parity();
        test_timeout();
        test_back_to_back();
        test_saturation();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
